// File: rtl/seq_mem_2r1w_rf_param.sv
// seq_mem_2r1w_rf_param
// Register file with two registered read ports and one write port.
// A clear sequencer zeroes every entry after reset and when clear is pulsed.
// With BYPASS=1, a read of the address being written returns the new data.
module seq_mem_2r1w_rf_param #(
  parameter int NBITS    = 8,
  parameter int NENTRIES = 8,
  parameter int BYPASS   = 1,
  localparam int AW      = (NENTRIES > 1) ? $clog2(NENTRIES) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  output logic             ready,
  input  logic             read0_en,
  input  logic [AW-1:0]    read0_addr,
  output logic             read0_val,
  output logic [NBITS-1:0] read0_data,
  input  logic             read1_en,
  input  logic [AW-1:0]    read1_addr,
  output logic             read1_val,
  output logic [NBITS-1:0] read1_data,
  input  logic             write_en,
  input  logic [AW-1:0]    write_addr,
  input  logic [NBITS-1:0] write_data
);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam logic [AW-1:0] LAST_PTR = AW'(NENTRIES - 1);

  state_t            state_r;
  logic [AW-1:0]     clear_ptr_r;
  logic [NBITS-1:0]  mem_r [NENTRIES];

  logic              mem_we_s;
  logic [AW-1:0]     mem_waddr_s;
  logic [NBITS-1:0]  mem_wdata_s;
  logic [NBITS-1:0]  rd0_data_s;
  logic [NBITS-1:0]  rd1_data_s;

  // Array write port: the sweep owns it in CLEAR, the user write in READY.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_waddr_s = '0;
    mem_wdata_s = '0;
    case (state_r)
      ST_CLEAR: begin
        mem_we_s    = 1'b1;
        mem_waddr_s = clear_ptr_r;
        mem_wdata_s = '0;
      end
      ST_READY: begin
        if (!clear && write_en) begin
          mem_we_s    = 1'b1;
          mem_waddr_s = write_addr;
          mem_wdata_s = write_data;
        end else begin
          mem_we_s    = 1'b0;
          mem_waddr_s = '0;
          mem_wdata_s = '0;
        end
      end
      default: begin
        mem_we_s    = 1'b0;
        mem_waddr_s = '0;
        mem_wdata_s = '0;
      end
    endcase
  end

  // Read data selection; each port bypasses the coincident write independently.
  always_comb begin
    rd0_data_s = mem_r[read0_addr];
    rd1_data_s = mem_r[read1_addr];
    if ((BYPASS != 0) && write_en && (write_addr == read0_addr)) begin
      rd0_data_s = write_data;
    end else begin
      rd0_data_s = mem_r[read0_addr];
    end
    if ((BYPASS != 0) && write_en && (write_addr == read1_addr)) begin
      rd1_data_s = write_data;
    end else begin
      rd1_data_s = mem_r[read1_addr];
    end
  end

  // Storage array; intentionally unreset, the clear sweep gives it a known state.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[mem_waddr_s] <= mem_wdata_s;
    end
  end

  // Clear/ready sequencer with registered ready and read-port outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_CLEAR;
      clear_ptr_r <= '0;
      ready       <= 1'b0;
      read0_val   <= 1'b0;
      read0_data  <= '0;
      read1_val   <= 1'b0;
      read1_data  <= '0;
    end else begin
      case (state_r)
        ST_CLEAR: begin
          read0_val <= 1'b0;
          read1_val <= 1'b0;
          if (clear) begin
            clear_ptr_r <= '0;
          end else if (clear_ptr_r == LAST_PTR) begin
            state_r     <= ST_READY;
            ready       <= 1'b1;
            clear_ptr_r <= '0;
          end else begin
            clear_ptr_r <= clear_ptr_r + AW'(1);
          end
        end
        ST_READY: begin
          if (clear) begin
            state_r     <= ST_CLEAR;
            clear_ptr_r <= '0;
            ready       <= 1'b0;
            read0_val   <= 1'b0;
            read1_val   <= 1'b0;
          end else begin
            read0_val <= read0_en;
            read1_val <= read1_en;
            if (read0_en) begin
              read0_data <= rd0_data_s;
            end
            if (read1_en) begin
              read1_data <= rd1_data_s;
            end
          end
        end
        default: begin
          state_r     <= ST_CLEAR;
          clear_ptr_r <= '0;
          ready       <= 1'b0;
          read0_val   <= 1'b0;
          read1_val   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mem_2r1w_rf_param.sv
// Bench for seq_mem_2r1w_rf_param: directed stimulus, expected read data
// queued per port and checked by a monitor when the DUT raises read*_val.
module tb_seq_mem_2r1w_rf_param;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       clear;
  logic       ready;
  logic       read0_en, read1_en, write_en;
  logic [2:0] read0_addr, read1_addr, write_addr;
  logic [7:0] write_data;
  logic       read0_val, read1_val;
  logic [7:0] read0_data, read1_data;

  logic       ready_nb, r0v_nb, r1v_nb;
  logic [7:0] r0d_nb, r1d_nb;

  int total = 0;
  int bad   = 0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];

  seq_mem_2r1w_rf_param #(.NBITS(8), .NENTRIES(8), .BYPASS(1)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .ready(ready),
    .read0_en(read0_en), .read0_addr(read0_addr), .read0_val(read0_val), .read0_data(read0_data),
    .read1_en(read1_en), .read1_addr(read1_addr), .read1_val(read1_val), .read1_data(read1_data),
    .write_en(write_en), .write_addr(write_addr), .write_data(write_data)
  );

  seq_mem_2r1w_rf_param #(.NBITS(8), .NENTRIES(8), .BYPASS(0)) dut_nb (
    .clk(clk), .reset_n(reset_n), .clear(clear), .ready(ready_nb),
    .read0_en(read0_en), .read0_addr(read0_addr), .read0_val(r0v_nb), .read0_data(r0d_nb),
    .read1_en(read1_en), .read1_addr(read1_addr), .read1_val(r1v_nb), .read1_data(r1d_nb),
    .write_en(write_en), .write_addr(write_addr), .write_data(write_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus; acc=1 means the reads are expected to be accepted.
  task automatic step(input logic r0e, input logic [2:0] r0a, input logic [7:0] r0x,
                      input logic r1e, input logic [2:0] r1a, input logic [7:0] r1x,
                      input logic we, input logic [2:0] wa, input logic [7:0] wd,
                      input logic clr, input logic acc);
    read0_en = r0e; read0_addr = r0a;
    read1_en = r1e; read1_addr = r1a;
    write_en = we;  write_addr = wa; write_data = wd;
    clear = clr;
    if (acc && r0e) q0.push_back(r0x);
    if (acc && r1e) q1.push_back(r1x);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
  endtask

  // Monitor: every valid read must match the next queued expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (read0_val === 1'b1) begin
        if (q0.size() == 0) chk("port0_unexpected_val", 32'(read0_val), 32'd0);
        else chk("port0_data", 32'(read0_data), 32'(q0.pop_front()));
      end
      if (read1_val === 1'b1) begin
        if (q1.size() == 0) chk("port1_unexpected_val", 32'(read1_val), 32'd0);
        else chk("port1_data", 32'(read1_data), 32'(q1.pop_front()));
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    clear = 1'b0; read0_en = 1'b0; read1_en = 1'b0; write_en = 1'b0;
    read0_addr = 3'd0; read1_addr = 3'd0; write_addr = 3'd0; write_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", 32'(ready), 32'd0);
    chk("reset_val0", 32'(read0_val), 32'd0);
    chk("reset_data0", 32'(read0_data), 32'd0);
    chk("reset_data1", 32'(read1_data), 32'd0);
    reset_n = 1'b1;

    // Initial sweep: ready after exactly 8 edges.
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #1;
      chk("sweep_ready", 32'(ready), (i == 8) ? 32'd1 : 32'd0);
    end
    chk("sweep_ready_nb", 32'(ready_nb), 32'd1);

    // Everything reads zero after the sweep.
    for (int i = 0; i < 8; i++)
      step(1'b1, 3'(i), 8'h00, 1'b1, 3'(7 - i), 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1);
    idle();

    // Write then dual read of the same entry.
    step(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 8'hA5, 1'b0, 1'b1);
    step(1'b1, 3'd3, 8'hA5, 1'b1, 3'd3, 8'hA5, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1);
    idle();

    // Bypass vs non-bypass on a coincident write/read.
    step(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b1, 3'd6, 8'h11, 1'b0, 1'b1);
    step(1'b1, 3'd6, 8'h5A, 1'b0, 3'd0, 8'h00, 1'b1, 3'd6, 8'h5A, 1'b0, 1'b1);
    chk("nobypass_data", 32'(r0d_nb), 32'h11);
    chk("nobypass_val", 32'(r0v_nb), 32'd1);
    chk("nobypass_r1val", 32'(r1v_nb), 32'd0);
    chk("nobypass_r1hold", 32'(r1d_nb), 32'hA5);
    step(1'b1, 3'd6, 8'h5A, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1);
    chk("nobypass_followup", 32'(r0d_nb), 32'h5A);
    idle();

    // Fill, then clear with a coincident write to addr 0.
    for (int i = 0; i < 8; i++)
      step(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b1, 3'(i), 8'(8'h10 + i), 1'b0, 1'b1);
    step(1'b1, 3'd0, 8'h10, 1'b1, 3'd7, 8'h17, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1);
    step(1'b1, 3'd1, 8'h00, 1'b1, 3'd2, 8'h00, 1'b1, 3'd0, 8'hFF, 1'b1, 1'b0);
    chk("clear_ready_drop", 32'(ready), 32'd0);
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 3'(i - 1), 8'h00, 1'b1, 3'd0, 8'h00, 1'b1, 3'(i - 1), 8'hEE, 1'b0, 1'b0);
      chk("clear_ready", 32'(ready), (i == 8) ? 32'd1 : 32'd0);
    end
    for (int i = 0; i < 8; i++)
      step(1'b1, 3'(i), 8'h00, 1'b1, 3'(7 - i), 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1);
    idle();

    // Restart the sweep mid-way at clear_ptr=5.
    step(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0);
    repeat (5) idle();
    step(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0);
    chk("restart_ready0", 32'(ready), 32'd0);
    for (int i = 1; i <= 8; i++) begin
      idle();
      chk("restart_ready", 32'(ready), (i == 8) ? 32'd1 : 32'd0);
    end

    // Read data holds when val drops; async reset clears it at once.
    step(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 8'h77, 1'b0, 1'b1);
    step(1'b1, 3'd2, 8'h77, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("hold_val", 32'(read0_val), 32'd0);
      chk("hold_data", 32'(read0_data), 32'h77);
    end
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_data", 32'(read0_data), 32'h00);
    chk("async_rst_ready", 32'(ready), 32'd0);
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_mem_2r1w_rf_param.md
# seq_mem_2r1w_rf_param

Parametrised register file with two registered read ports and one write port. Built-in clear sequencer zeroes every entry after reset and on request. Optional write-to-read bypass. Serves as the general storage primitive for datapath register files and small lookup tables that need more than one read per cycle and a known initial state.

## Interface

- NBITS, 8: entry width in bits, ≥1.
- NENTRIES, 8: number of entries, a power of two ≥2. AW = $clog2(NENTRIES).
- BYPASS, 1: 1 = a read that coincides with a write to the same address returns the new data. 0 = it returns the old data.

- clk  in  1  clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- clear  in  1  single-cycle request to re-zero all entries.
- ready  out  1  array is usable; reads and writes are accepted only when this is high.
- read0_en  in  1  port 0 read request.
- read0_addr  in  AW  port 0 read address.
- read0_val  out  1  port 0 data is valid this cycle.
- read0_data  out  NBITS  port 0 read data.
- read1_en, read1_addr, read1_val, read1_data: same as port 0, for port 1.
- write_en  in  1  write request.
- write_addr  in  AW  write address.
- write_data  in  NBITS  write data.

## Operation

- Storage is NENTRIES×NBITS. The array itself has no reset; the clear sequencer initialises it.
- The FSM has two states, CLEAR and READY.
- Reset (reset_n low): state=CLEAR, clear_ptr=0, ready=0, read*_val=0, read*_data=0.
- In CLEAR, on each edge:
  - mem[clear_ptr] ← 0 and clear_ptr increments.
  - If clear_ptr==NENTRIES-1, the next state is READY and ready←1.
- In READY, clear=1 sends the FSM to CLEAR with clear_ptr=0 and ready←0.
- clear=1 while already in CLEAR restarts the sweep: clear_ptr←0.
- When ready=0, the block ignores read*_en and write_en: no array update, and read*_val←0 on the next edge.
- On a READY edge where clear=1:
  - The write is dropped.
  - Reads are dropped (read*_val←0).
  - The entry-0 zeroing begins on the following edge.
- Write: in READY with clear=0 and write_en=1, mem[write_addr]←write_data at the edge.
- Read on port p: in READY with clear=0, at the edge:
  - read_p_val←read_p_en.
  - If read_p_en=1, read_p_data←mem[read_p_addr] as it was before the edge.
  - Exception: if BYPASS=1, write_en=1 and write_addr==read_p_addr, read_p_data←write_data.
- Both read ports may address the same entry in the same cycle, and each port applies bypass independently.
- When read_p_val is 0, read_p_data holds its last value; it is not zeroed.

## Timing

- Clear sweep takes NENTRIES edges.
  - After reset_n rises, the first rising edge zeroes entry 0.
  - ready is high after edge NENTRIES, so it is first sampled high in cycle NENTRIES+1.
  - A clear pulse in READY costs NENTRIES+1 cycles before ready returns to 1.
- Read latency is 1 cycle: address and enable are sampled at edge k; data and val are valid after edge k until edge k+1.
- Write latency: a non-bypassed read issued in the cycle after the write returns the new value.
- Asynchronous reset mid-sweep or mid-read:
  - All outputs go to their reset values immediately.
  - Any in-flight read is lost.
  - The sweep restarts from 0 once reset_n deasserts.
- Address width: all addresses are AW bits. No out-of-range addresses are possible, and the counter does not wrap beyond NENTRIES-1.

## Test plan

- Reset with defaults, then hold reset_n=1 with no activity:
  - ready=0 for 8 edges, then 1.
  - Reading addresses 0–7 on both ports returns 0x00 with val=1 one cycle later.
- Write 0xA5 to addr 3, then read addr 3 on port 0 and addr 3 on port 1 the next cycle: both return 0xA5, val=1.
- Simultaneous write 0x5A to addr 6 and port-0 read of addr 6 (old value 0x11):
  - BYPASS=1 returns 0x5A.
  - BYPASS=0 returns 0x11.
  - A follow-up read returns 0x5A in both cases.
- Fill all 8 entries with 0x10+i, pulse clear together with a write of 0xFF to addr 0:
  - ready=0 for 9 cycles.
  - Reads and writes issued meanwhile have val=0 and no effect.
  - Afterwards all entries read 0x00, including addr 0.
- Pulse clear again when clear_ptr=5 mid-sweep: ready rises exactly 8 edges after the second pulse.
- Write 0x77 to addr 2, read addr 2 with read0_en=1, then deassert read0_en for 3 cycles:
  - read0_val drops to 0 and read0_data holds 0x77.
  - Asserting reset_n=0 asynchronously clears read0_data to 0x00 and ready to 0 immediately.
